// File: rtl/fetch_pkg.sv
// Shared widths, halt encoding and FSM states for the instruction fetch unit.
// Pure declarations: no logic, no latency.
package fetch_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry shift FIFO of {pc, data}; head is always entry 0 and holds its last value when empty.
// Zero-latency head; push+pop in the same cycle is allowed at any occupancy, flush drops all.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int EW = ADDR_W + DATA_W;

  logic [1:0]    count_q, count_d;
  logic [EW-1:0] e0_q, e0_d;
  logic [EW-1:0] e1_q, e1_d;
  logic [EW-1:0] in_ent;

  assign in_ent = {push_pc_i, push_data_i};

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      // Entries are left untouched so the head outputs keep their last value.
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = in_ent;
          end else begin
            e0_d = in_ent;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) e0_d = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) e0_d = in_ent;
          else                 e1_d = in_ent;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = e0_q[EW-1:DATA_W];
  assign head_data_o = e0_q[DATA_W-1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetches words from instruction memory once loading completes and hands {data, pc} to decode.
// First word valid 3 edges after load_complete; credit rule stops issue when buffer + in-flight would exceed 2.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_complete,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              stop_q, stop_d;

  logic [1:0] buf_count;
  logic [2:0] occupancy;
  logic       pop, branch_take, resp_wr, halt_xfer;

  assign instr_valid = (buf_count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign branch_take = (state_q == FETCH) & branch_valid;
  // Responses arriving after the halt word was buffered, or during a redirect, are dropped.
  assign resp_wr     = inflight_q & ~branch_take & ~stop_q;
  assign halt_xfer   = pop & (instr_data == HALT_WORD);
  assign occupancy   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_read    = (state_q == FETCH) & ~stop_q & ~branch_valid & (occupancy < 3'd2);
  assign mem_addr    = pc_q;
  assign halted      = (state_q == HALT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = mem_read;
    inflight_pc_d = inflight_pc_q;
    stop_d        = stop_q;

    unique case (state_q)
      IDLE:    if (load_complete) state_d = FETCH;
      FETCH:   if (halt_xfer)     state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (branch_take) begin
      pc_d   = branch_target;
      stop_d = 1'b0;
    end else begin
      if (resp_wr && (mem_read_data == HALT_WORD)) stop_d = 1'b1;
      if (mem_read) begin
        pc_d          = pc_q + ADDR_W'(1);
        inflight_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      stop_q        <= stop_d;
    end
  end

  fetch_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .push_i     (resp_wr),
    .push_pc_i  (inflight_pc_q),
    .push_data_i(mem_read_data),
    .pop_i      (pop),
    .flush_i    (branch_take),
    .count_o    (buf_count),
    .head_pc_o  (instr_pc),
    .head_data_o(instr_data)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table for start-up and halt,
// hand-written sequences for backpressure, branch flush, PC wrap and async reset.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n, load_complete, branch_valid, instr_ready;
  logic [4:0]  branch_target, mem_addr, instr_pc;
  logic        mem_read, instr_valid, halted;
  logic [15:0] mem_read_data = 16'h0;
  logic [15:0] instr_data;
  logic [15:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_read) mem_read_data <= mem[mem_addr];

  instruction_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_complete(load_complete),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_read_data(mem_read_data),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .halted       (halted)
  );

  typedef struct {
    logic        lc;
    logic        rdy;
    logic        bv;
    logic [4:0]  bt;
    logic        e_rd;
    logic [4:0]  e_addr;
    logic        e_vld;
    logic [15:0] e_dat;
    logic [4:0]  e_pc;
    logic        e_halt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    load_complete = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 5'd0;
    instr_ready   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for the next transfer; returns at the following negedge.
  task automatic get_xfer(output logic [4:0] p, output logic [15:0] d);
    bit got;
    got = 1'b0;
    p   = '0;
    d   = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (instr_valid && instr_ready) begin
        got = 1'b1;
        p   = instr_pc;
        d   = instr_data;
      end
      @(negedge clock);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: got none expected a transfer within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [4:0]  p;
    logic [15:0] d;
    int          reads, bad;

    // Start-up latency, 1/cycle stream, halt and post-halt behaviour.
    for (int i = 0; i < 32; i++)
      mem[i] = (i < 5) ? 16'h1000 + 16'(i) : ((i == 5) ? 16'hFFFF : 16'h0);

    vt[0]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000, 5'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 16'h0000, 5'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 16'h0000, 5'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 16'h1000, 5'd0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 16'h1001, 5'd1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 16'h1002, 5'd2, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 16'h1003, 5'd3, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 16'h1004, 5'd4, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 16'hFFFF, 5'd5, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 16'hFFFF, 5'd5, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd7, 1'b0, 16'hFFFF, 5'd5, 1'b1};
    vt[11] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 16'hFFFF, 5'd5, 1'b1};

    do_reset();
    #1;
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst rd", 32'(mem_read), 32'd0);
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      load_complete = vt[i].lc;
      instr_ready   = vt[i].rdy;
      branch_valid  = vt[i].bv;
      branch_target = vt[i].bt;
      #1;
      chk($sformatf("v%0d rd", i),   32'(mem_read),    32'(vt[i].e_rd));
      chk($sformatf("v%0d addr", i), 32'(mem_addr),    32'(vt[i].e_addr));
      chk($sformatf("v%0d vld", i),  32'(instr_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d dat", i),  32'(instr_data),  32'(vt[i].e_dat));
      chk($sformatf("v%0d pc", i),   32'(instr_pc),    32'(vt[i].e_pc));
      chk($sformatf("v%0d halt", i), 32'(halted),      32'(vt[i].e_halt));
      @(negedge clock);
    end
    branch_valid = 1'b0;
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mem_read) reads++;
      @(negedge clock);
    end
    chk("halt no reads", 32'(reads), 32'd0);

    // Backpressure: only two reads may be outstanding/buffered.
    for (int i = 0; i < 32; i++) mem[i] = 16'h2000 + 16'(i);
    do_reset();
    load_complete = 1'b1;
    instr_ready   = 1'b0;
    reads = 0;
    bad   = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (mem_read) reads++;
      if (instr_valid && (instr_data !== 16'h2000 || instr_pc !== 5'd0)) bad++;
      @(negedge clock);
    end
    chk("bp reads", 32'(reads), 32'd2);
    chk("bp head stable", 32'(bad), 32'd0);
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      get_xfer(p, d);
      chk($sformatf("bp pc%0d", k), 32'(p), 32'(k));
      chk($sformatf("bp dat%0d", k), 32'(d), 32'(16'h2000 + 16'(k)));
    end

    // Branch during a full-rate stream: transfer completes, buffer and in-flight dropped.
    branch_valid  = 1'b1;
    branch_target = 5'd20;
    #1;
    chk("br rd", 32'(mem_read), 32'd0);
    chk("br xfer vld", 32'(instr_valid), 32'd1);
    chk("br xfer pc", 32'(instr_pc), 32'd6);
    @(negedge clock);
    branch_valid = 1'b0;
    #1;
    chk("br next rd", 32'(mem_read), 32'd1);
    chk("br next addr", 32'(mem_addr), 32'd20);
    chk("br flushed", 32'(instr_valid), 32'd0);
    @(negedge clock);
    for (int k = 20; k < 32; k++) begin
      get_xfer(p, d);
      chk($sformatf("seq pc%0d", k), 32'(p), 32'(k));
      chk($sformatf("seq dat%0d", k), 32'(d), 32'(16'h2000 + 16'(k)));
    end
    get_xfer(p, d);
    chk("wrap pc", 32'(p), 32'd0);
    chk("wrap dat", 32'(d), 32'h2000);

    // Branch to the last address, then wrap.
    branch_valid  = 1'b1;
    branch_target = 5'd31;
    @(negedge clock);
    branch_valid = 1'b0;
    get_xfer(p, d);
    chk("br31 pc", 32'(p), 32'd31);
    chk("br31 dat", 32'(d), 32'h201F);
    get_xfer(p, d);
    chk("br31 wrap pc", 32'(p), 32'd0);

    // Asynchronous reset mid-stream.
    #1;
    chk("pre-rst vld", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst rd", 32'(mem_read), 32'd0);
    chk("arst addr", 32'(mem_addr), 32'd0);
    chk("arst vld", 32'(instr_valid), 32'd0);
    chk("arst dat", 32'(instr_data), 32'd0);
    chk("arst pc", 32'(instr_pc), 32'd0);
    chk("arst halt", 32'(halted), 32'd0);
    load_complete = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    reads = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_read || instr_valid) reads++;
      @(negedge clock);
    end
    chk("idle wait", 32'(reads), 32'd0);
    load_complete = 1'b1;
    @(negedge clock);
    #1;
    chk("restart rd", 32'(mem_read), 32'd1);
    chk("restart addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    get_xfer(p, d);
    chk("restart pc", 32'(p), 32'd0);
    chk("restart dat", 32'(d), 32'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
